// File: rtl/hls_call_ctrl_pkg.sv
// hls_call_ctrl shared types and defaults.
// State encoding for the ap_ctrl_hs call sequencer.
package hls_call_ctrl_pkg;

  localparam int unsigned DATA_W_D = 32;
  localparam int unsigned CNT_W_D  = 26;
  localparam int unsigned TIMEOUT_D = 5000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic logic in_call(state_t s);
    return (s == ST_START) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/hls_call_ctrl_if.sv
// ap_ctrl_hs handshake bundle between controller and HLS core.
// master = controller side, slave = HLS core side.
interface hls_call_ctrl_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              ap_start;
  logic              ap_ready;
  logic              ap_done;
  logic              ap_idle;
  logic [DATA_W-1:0] ap_return;

  modport master (
    output ap_start,
    input  ap_ready,
    input  ap_done,
    input  ap_idle,
    input  ap_return
  );

  modport slave (
    input  ap_start,
    output ap_ready,
    output ap_done,
    output ap_idle,
    output ap_return
  );

endinterface

// File: rtl/hls_call_ctrl_cycle_timer.sv
// Call-duration counter with terminal-count compare.
// Held at zero while cleared; stops advancing when not enabled.
module cycle_timer #(
  parameter int unsigned       CNT_W   = 26,
  parameter logic [CNT_W-1:0]  TIMEOUT = CNT_W'(5000000)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  // count register: clear wins over enable
  always_ff @(posedge CLK) begin
    if (!RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == TIMEOUT);

endmodule

// File: rtl/hls_call_ctrl.sv
// Runs one ap_ctrl_hs call per accepted trigger pulse.
// Captures ap_return and cycle count, aborts on timeout.
module hls_call_ctrl
  import hls_call_ctrl_pkg::*;
#(
  parameter int unsigned      DATA_W  = DATA_W_D,
  parameter int unsigned      CNT_W   = CNT_W_D,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_D)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               trig,
  hls_call_ctrl_if.master    hls,
  output logic               busy,
  output logic [DATA_W-1:0]  result,
  output logic               result_valid,
  output logic [CNT_W-1:0]   cycles,
  output logic               timeout
);

  state_t           state;
  state_t           state_n;
  logic             cap;
  logic             abort;
  logic             hit;
  logic [CNT_W-1:0] count;

  cycle_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (state == ST_IDLE),
    .en    (in_call(state)),
    .count (count),
    .hit   (hit)
  );

  // state register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next state; a done on the timeout cycle still completes
  always_comb begin
    state_n = state;
    cap     = 1'b0;
    abort   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (trig && hls.ap_idle) begin
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (hls.ap_done) begin
          cap     = 1'b1;
          state_n = ST_IDLE;
        end else if (hit) begin
          abort   = 1'b1;
          state_n = ST_DRAIN;
        end else if (hls.ap_ready) begin
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (hls.ap_done) begin
          cap     = 1'b1;
          state_n = ST_IDLE;
        end else if (hit) begin
          abort   = 1'b1;
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (hls.ap_idle) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // result capture and one-cycle status pulses
  always_ff @(posedge CLK) begin
    if (!RST) begin
      result       <= '0;
      cycles       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      result_valid <= cap;
      timeout      <= abort;
      if (cap) begin
        result <= hls.ap_return;
        cycles <= count;
      end
    end
  end

  assign hls.ap_start = (state == ST_START);
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_hls_call_ctrl.sv
// Directed + randomized bench for hls_call_ctrl.
// Model: per-call outcome from ready/done offsets vs TIMEOUT.
module tb_hls_call_ctrl;

  localparam int TO = 20;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        trig = 1'b0;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic [25:0] cycles;
  logic        timeout;

  hls_call_ctrl_if #(.DATA_W(32)) hif ();

  hls_call_ctrl #(
    .DATA_W  (32),
    .CNT_W   (26),
    .TIMEOUT (26'd20)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .trig         (trig),
    .hls          (hif),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .cycles       (cycles),
    .timeout      (timeout)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_result = '0;
  logic [25:0] exp_cycles = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit s, input bit b,
                         input bit rv, input bit to);
    chk({tag, ".ap_start"}, 64'(hif.ap_start), 64'(s));
    chk({tag, ".busy"}, 64'(busy), 64'(b));
    chk({tag, ".result_valid"}, 64'(result_valid), 64'(rv));
    chk({tag, ".timeout"}, 64'(timeout), 64'(to));
    chk({tag, ".result"}, 64'(result), 64'(exp_result));
    chk({tag, ".cycles"}, 64'(cycles), 64'(exp_cycles));
  endtask

  // Entered at a negedge with DUT idle. rdy/dn are cycle offsets
  // from the first ap_start cycle; dn > TO means no done in time.
  task automatic run_call(input string tag, input int rdy, input int dn,
                          input logic [31:0] ret, input int d,
                          input bit noise);
    bit completes;
    int endk;
    completes = (dn <= TO);
    endk = completes ? dn : TO;
    hif.ap_idle = 1'b1;
    trig = 1'b1;
    for (int k = 0; k <= endk; k++) begin
      @(negedge CLK);
      chk_all(tag, (k <= rdy), 1'b1, 1'b0, 1'b0);
      hif.ap_idle   = 1'b0;
      hif.ap_ready  = (k == rdy);
      hif.ap_done   = (k == dn);
      hif.ap_return = (k == dn) ? ret : $urandom;
      trig = noise && ($urandom_range(0, 3) == 0);
    end
    @(negedge CLK);
    trig = 1'b0;
    hif.ap_ready = 1'b0;
    hif.ap_done  = 1'b0;
    if (completes) begin
      exp_result = ret;
      exp_cycles = 26'(dn);
      chk_all({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b0);
      hif.ap_idle = 1'b1;
      @(negedge CLK);
      chk_all({tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      chk_all({tag, ".abort"}, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int j = 0; j <= d; j++) begin
        hif.ap_idle   = (j == d);
        hif.ap_done   = (j == 0) && (d > 0);
        hif.ap_return = $urandom;
        trig = noise && ($urandom_range(0, 1) == 0);
        @(negedge CLK);
        trig = 1'b0;
        hif.ap_done = 1'b0;
        chk_all({tag, ".drain"}, 1'b0, (j < d), 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    int rdy;
    int dn;
    hif.ap_ready  = 1'b0;
    hif.ap_done   = 1'b0;
    hif.ap_idle   = 1'b1;
    hif.ap_return = '0;

    repeat (2) @(negedge CLK);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    run_call("basic", 2, 10, 32'h0000_0707, 0, 1'b0);
    run_call("first", 0, 0, 32'd5, 0, 1'b0);
    run_call("coinc", 1, TO, 32'hCAFE_0001, 0, 1'b0);
    run_call("tmo", 3, 1000, 32'hDEAD_BEEF, 4, 1'b0);
    run_call("tmo_rdy_late", 1000, 1000, 32'h1, 0, 1'b0);

    trig = 1'b1;
    hif.ap_idle = 1'b0;
    @(negedge CLK);
    chk_all("trig_notidle", 1'b0, 1'b0, 1'b0, 1'b0);
    trig = 1'b0;
    hif.ap_idle = 1'b1;
    @(negedge CLK);
    chk_all("trig_notidle2", 1'b0, 1'b0, 1'b0, 1'b0);
    run_call("trig_busy", 3, 12, 32'h0000_1234, 2, 1'b1);
    run_call("trig_drain", 2, 1000, 32'h0, 3, 1'b1);

    hif.ap_idle = 1'b1;
    trig = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge CLK);
      trig = 1'b0;
      chk_all("prerst", (k == 0), 1'b1, 1'b0, 1'b0);
      hif.ap_ready = (k == 0);
      hif.ap_idle  = 1'b0;
    end
    RST = 1'b0;
    hif.ap_ready = 1'b0;
    exp_result = '0;
    exp_cycles = '0;
    repeat (3) begin
      @(negedge CLK);
      chk_all("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    RST = 1'b1;
    hif.ap_done = 1'b1;
    hif.ap_return = 32'h5555_AAAA;
    @(negedge CLK);
    chk_all("postrst", 1'b0, 1'b0, 1'b0, 1'b0);
    hif.ap_done = 1'b0;
    hif.ap_idle = 1'b1;
    @(negedge CLK);
    chk_all("postrst2", 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rdy = $urandom_range(0, 24);
      dn  = rdy + $urandom_range(0, 8);
      run_call("rand", rdy, dn, $urandom, $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
